fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch and PC sequencer for the rv32i core. It consumes the ALU's branch_type/result outputs as redirect commands and drives the instruction-memory request/response interface. It presents fetched instructions, tagged with their PC, to decode over a valid/ready handshake. It allows at most one outstanding memory request and discards stale responses after a redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset; bits[1:0] must be 0.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  read data valid; in order; at least 1 cycle after request accept
imem_rsp_data  in  32  instruction word
inst_valid  out  1  instruction to decode valid
inst_ready  in  1  decode accepts instruction
inst_data  out  32  instruction word
inst_pc  out  32  PC of inst_data
redirect_valid  in  1  execute stage resolves a control transfer this cycle
branch_type  in  branch_type_e  BRANCH_NONE / BRANCH_RELATIVE / BRANCH_ABSOLUTE, from ALU
branch_pc  in  32  PC of the redirecting instruction
branch_imm  in  32  sign-extended B/J immediate
alu_result  in  32  ALU result; JALR target

Behaviour:
- Redirect is taken only when redirect_valid=1 and branch_type!=BRANCH_NONE. Target: RELATIVE gives branch_pc+branch_imm; ABSOLUTE gives alu_result. Both are mod 2^32. pc loads {target[31:2],2'b00}.
- Reset: state=REQ, pc=RESET_PC. Outputs during and on the cycle after reset: imem_req_valid=0, inst_valid=0, imem_req_addr=RESET_PC, inst_data=0, inst_pc=0. The first request is asserted on the 2nd cycle after rst deasserts. The bench uses a start flag for this.
- The memory is reset by the same rst. rsp_valid is ignored in REQ and HOLD.
- Sequential PC: pc+4, wrapping 0xFFFF_FFFC to 0x0000_0000.
- FSM states: REQ, WAIT, HOLD, DROP. All outputs are registered. imem_req_addr always equals pc.
- REQ (imem_req_valid=1):
  - Request handshake and no redirect: fetch_pc<=pc, pc<=pc+4, go to WAIT.
  - Redirect and no handshake: pc<=target, stay in REQ. The address changes next cycle, which is permitted because no handshake occurred.
  - Redirect and handshake in the same cycle: pc<=target, go to DROP.
- WAIT (req_valid=0):
  - rsp_valid and no redirect: inst_data<=rsp_data, inst_pc<=fetch_pc, go to HOLD. inst_valid=1 the following cycle.
  - Redirect and rsp_valid in the same cycle: the response is discarded, pc<=target, go to REQ.
  - Redirect without rsp_valid: pc<=target, go to DROP.
- HOLD (inst_valid=1, req_valid=0):
  - inst_data and inst_pc stay stable while inst_ready=0.
  - inst_ready and no redirect: inst_valid<=0, go to REQ.
  - Redirect (priority over inst_ready): inst_valid<=0, pc<=target, go to REQ. Decode squashes its own copy if it sampled the word.
- DROP (req_valid=0, inst_valid=0):
  - rsp_valid: the response is discarded, go to REQ.
  - A further redirect while in DROP: pc<=new target, stay in DROP. If it coincides with rsp_valid, the response is discarded and the FSM goes to REQ with the new target.
- Throughput: one instruction per 3 cycles minimum with a 1-cycle memory.
- branch_type/branch_pc/branch_imm/alu_result are sampled only when redirect_valid=1.

Test Plan:
1. RESET_PC=0x100, 1-cycle memory returns 0x00000013 -> first req addr 0x100; inst_valid with inst_pc=0x100, inst_data=0x13; next req addr 0x104.
2. inst_ready=0 for 5 cycles in HOLD -> inst_data/inst_pc unchanged, imem_req_valid=0 throughout; after ready, next req addr = inst_pc+4.
3. In WAIT, redirect RELATIVE with branch_pc=0x200, branch_imm=0xFFFF_FFF0, memory responds 2 cycles later -> response dropped, inst_valid stays 0, next req addr 0x1F0.
4. Redirect ABSOLUTE, alu_result=0x0000_1003, in HOLD with inst_ready=1 in the same cycle -> inst_valid falls, next req addr 0x1000.
5. Redirect in the same cycle as a REQ handshake at 0x40, target 0x80 -> DROP; response for 0x40 never appears on inst_*; next req addr 0x80. A second redirect to 0xC0 while in DROP -> next req addr 0xC0.
6. pc=0xFFFF_FFFC fetch -> next req addr 0x0. rst asserted mid-WAIT -> outputs return to reset values and the first req is again RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: rv32i instruction fetch and PC sequencer.
// One outstanding imem request; responses made stale by a redirect are dropped.
package fetch_pkg;
    typedef enum logic [1:0] {
        BRANCH_NONE     = 2'd0,
        BRANCH_RELATIVE = 2'd1,
        BRANCH_ABSOLUTE = 2'd2
    } branch_type_e;
endpackage

module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [31:0]  imem_req_addr,
    input  logic         imem_rsp_valid,
    input  logic [31:0]  imem_rsp_data,
    output logic         inst_valid,
    input  logic         inst_ready,
    output logic [31:0]  inst_data,
    output logic [31:0]  inst_pc,
    input  logic         redirect_valid,
    input  branch_type_e branch_type,
    input  logic [31:0]  branch_pc,
    input  logic [31:0]  branch_imm,
    input  logic [31:0]  alu_result
);

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DROP
    } state_e;

    state_e      state;
    state_e      state_n;
    logic        started;
    logic [31:0] pc;
    logic [31:0] pc_n;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_n;
    logic [31:0] data_n;
    logic [31:0] ipc_n;
    logic        req_valid_n;
    logic        inst_valid_n;
    logic        take;
    logic        hs;
    logic [31:0] target;
    logic [31:0] target_raw;

    assign take          = redirect_valid && (branch_type != BRANCH_NONE);
    assign hs            = imem_req_valid && imem_req_ready;
    assign imem_req_addr = pc;

    always_comb begin
        target_raw = alu_result;
        if (branch_type == BRANCH_RELATIVE) begin
            target_raw = branch_pc + branch_imm;
        end
        target = {target_raw[31:2], 2'b00};
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        fetch_pc_n = fetch_pc;
        data_n     = inst_data;
        ipc_n      = inst_pc;
        unique case (state)
            REQ: begin
                if (take) begin
                    pc_n = target;
                    if (hs) begin
                        state_n = DROP;
                    end
                end else if (hs) begin
                    fetch_pc_n = pc;
                    pc_n       = pc + 32'd4;
                    state_n    = WAIT;
                end
            end
            WAIT: begin
                if (take) begin
                    pc_n    = target;
                    state_n = imem_rsp_valid ? REQ : DROP;
                end else if (imem_rsp_valid) begin
                    data_n  = imem_rsp_data;
                    ipc_n   = fetch_pc;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (take) begin
                    pc_n    = target;
                    state_n = REQ;
                end else if (inst_ready) begin
                    state_n = REQ;
                end
            end
            DROP: begin
                if (take) begin
                    pc_n = target;
                end
                if (imem_rsp_valid) begin
                    state_n = REQ;
                end
            end
            default: state_n = REQ;
        endcase
        // started holds off the first request one extra cycle after reset
        req_valid_n  = started && (state_n == REQ);
        inst_valid_n = (state_n == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= REQ;
            started        <= 1'b0;
            pc             <= RESET_PC;
            fetch_pc       <= '0;
            inst_data      <= '0;
            inst_pc        <= '0;
            imem_req_valid <= 1'b0;
            inst_valid     <= 1'b0;
        end else begin
            state          <= state_n;
            started        <= 1'b1;
            pc             <= pc_n;
            fetch_pc       <= fetch_pc_n;
            inst_data      <= data_n;
            inst_pc        <= ipc_n;
            imem_req_valid <= req_valid_n;
            inst_valid     <= inst_valid_n;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus random checks of fetch_unit against an
// architectural next-PC model and a memory model with variable latency.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic         clk;
    logic         rst;
    logic         imem_req_valid;
    logic         imem_req_ready;
    logic [31:0]  imem_req_addr;
    logic         imem_rsp_valid;
    logic [31:0]  imem_rsp_data;
    logic         inst_valid;
    logic         inst_ready;
    logic [31:0]  inst_data;
    logic [31:0]  inst_pc;
    logic         redirect_valid;
    branch_type_e branch_type;
    logic [31:0]  branch_pc;
    logic [31:0]  branch_imm;
    logic [31:0]  alu_result;

    int checks;
    int failures;
    int accepted;
    int mem_lat;
    int ready_mode;
    time t_first;
    logic [31:0] sb[$];

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .rst(rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_data(inst_data),
        .inst_pc(inst_pc),
        .redirect_valid(redirect_valid),
        .branch_type(branch_type),
        .branch_pc(branch_pc),
        .branch_imm(branch_imm),
        .alu_result(alu_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RESET_PC) return 32'h0000_0013;
        return {a[7:0], a[31:8]} ^ 32'h5EED_0003;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural model: next PC decode must see is the last redirect
    // target, or the previous delivered PC plus 4.
    initial begin
        logic [31:0] t;
        forever begin
            @(posedge clk);
            if (rst) begin
                sb.delete();
                sb.push_back(RESET_PC);
            end else if (redirect_valid && branch_type != BRANCH_NONE) begin
                if (branch_type == BRANCH_RELATIVE) t = branch_pc + branch_imm;
                else t = alu_result;
                sb.delete();
                sb.push_back(t & 32'hFFFF_FFFC);
            end
        end
    end

    // Instruction memory: one request in flight, fixed or random latency.
    initial begin
        logic        pend;
        int          cnt;
        logic [31:0] paddr;
        logic        hs;
        logic        rs;
        logic        fire;
        logic [31:0] a;
        pend = 1'b0;
        cnt = 0;
        paddr = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        forever begin
            @(negedge clk);
            hs = imem_req_valid && imem_req_ready;
            a = imem_req_addr;
            rs = rst;
            fire = imem_rsp_valid;
            @(posedge clk);
            #2;
            if (rs) begin
                pend = 1'b0;
            end else begin
                if (fire) pend = 1'b0;
                if (hs) begin
                    check("one_outstanding", 32'(pend), 32'd0);
                    pend = 1'b1;
                    paddr = a;
                    cnt = (mem_lat == 0) ? $urandom_range(0, 2) : mem_lat - 1;
                end else if (pend && cnt > 0) begin
                    cnt--;
                end
            end
            imem_rsp_valid = pend && (cnt == 0);
            imem_rsp_data = imem_rsp_valid ? mem_word(paddr) : 32'd0;
            case (ready_mode)
                0: imem_req_ready = 1'b0;
                1: imem_req_ready = 1'b1;
                default: imem_req_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops the expected PC on every decode handshake.
    initial begin
        logic        pv;
        logic [31:0] pp;
        logic [31:0] pd;
        logic [31:0] e;
        pv = 1'b0;
        pp = '0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                continue;
            end
            if (inst_valid && pv) begin
                check("hold_pc", inst_pc, pp);
                check("hold_data", inst_data, pd);
            end
            if (imem_req_valid && imem_req_ready) begin
                if (sb.size() == 0) check("req_sb_empty", 32'd1, 32'd0);
                else check("req_addr", imem_req_addr, sb[0]);
            end
            if (inst_valid && inst_ready) begin
                if (sb.size() == 0) begin
                    check("inst_sb_empty", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("inst_pc", inst_pc, e);
                    check("inst_data", inst_data, mem_word(e));
                    sb.push_back(e + 32'd4);
                    accepted++;
                end
            end
            pv = inst_valid && !inst_ready;
            pp = inst_pc;
            pd = inst_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_pulse(input branch_type_e t, input logic [31:0] bpc,
                                  input logic [31:0] imm, input logic [31:0] alu);
        redirect_valid = 1'b1;
        branch_type = t;
        branch_pc = bpc;
        branch_imm = imm;
        alu_result = alu;
        tick();
        redirect_valid = 1'b0;
        branch_type = BRANCH_NONE;
    endtask

    task automatic wait_req_hs(output logic [31:0] addr, output logic saw);
        bit found;
        found = 0;
        saw = 1'b0;
        addr = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (inst_valid) saw = 1'b1;
            if (imem_req_valid && imem_req_ready) begin
                addr = imem_req_addr;
                found = 1;
                break;
            end
        end
        if (!found) check("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_inst();
        bit found;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (inst_valid) begin
                found = 1;
                break;
            end
        end
        if (!found) check("inst_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_req_valid();
        bit found;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (imem_req_valid) begin
                found = 1;
                break;
            end
        end
        if (!found) check("reqv_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_inst_data", inst_data, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("start_req_valid", 32'(imem_req_valid), (k == 2) ? 32'd1 : 32'd0);
        end
        t_first = $time;
        check("first_req_addr", imem_req_addr, RESET_PC);
    endtask

    initial begin
        logic [31:0] a;
        logic        saw;
        logic [31:0] p0;
        logic [31:0] d0;
        checks = 0;
        failures = 0;
        accepted = 0;
        mem_lat = 1;
        ready_mode = 1;
        rst = 1'b1;
        inst_ready = 1'b1;
        redirect_valid = 1'b0;
        branch_type = BRANCH_NONE;
        branch_pc = '0;
        branch_imm = '0;
        alu_result = '0;

        do_reset();
        wait_inst();
        check("t1_inst_pc", inst_pc, RESET_PC);
        check("t1_inst_data", inst_data, 32'h0000_0013);
        wait_req_hs(a, saw);
        check("t1_next_addr", a, 32'h0000_0104);
        check("t1_throughput", 32'(int'(($time - t_first) / 10)), 32'd3);

        tick();
        mem_lat = 3;
        inst_ready = 1'b0;
        wait_inst();
        p0 = inst_pc;
        d0 = inst_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_stable_pc", inst_pc, p0);
            check("t2_stable_data", inst_data, d0);
            check("t2_no_req", 32'(imem_req_valid), 32'd0);
        end
        tick();
        inst_ready = 1'b1;
        wait_req_hs(a, saw);
        check("t2_next_addr", a, p0 + 32'd4);

        tick();
        redirect_pulse(BRANCH_RELATIVE, 32'h0000_0200, 32'hFFFF_FFF0, 32'hDEAD_BEE0);
        wait_req_hs(a, saw);
        check("t3_no_inst", 32'(saw), 32'd0);
        check("t3_next_addr", a, 32'h0000_01F0);

        tick();
        mem_lat = 1;
        inst_ready = 1'b0;
        wait_inst();
        tick();
        inst_ready = 1'b1;
        redirect_pulse(BRANCH_ABSOLUTE, 32'h0000_0500, 32'h0000_0040, 32'h0000_1003);
        @(negedge clk);
        check("t4_inst_fall", 32'(inst_valid), 32'd0);
        check("t4_req_valid", 32'(imem_req_valid), 32'd1);
        check("t4_next_addr", imem_req_addr, 32'h0000_1000);

        for (int v = 0; v < 2; v++) begin
            tick();
            ready_mode = 0;
            mem_lat = 4;
            wait_req_valid();
            tick();
            redirect_pulse(BRANCH_ABSOLUTE, 32'h0, 32'h0, 32'h0000_0040);
            @(negedge clk);
            check("t5_req_valid", 32'(imem_req_valid), 32'd1);
            check("t5_addr_40", imem_req_addr, 32'h0000_0040);
            tick();
            ready_mode = 1;
            redirect_pulse(BRANCH_ABSOLUTE, 32'h0, 32'h0, 32'h0000_0080);
            if (v == 1) redirect_pulse(BRANCH_RELATIVE, 32'h0000_00A0, 32'h0000_0020, 32'h0);
            wait_req_hs(a, saw);
            check("t5_no_inst", 32'(saw), 32'd0);
            check("t5_next_addr", a, (v == 1) ? 32'h0000_00C0 : 32'h0000_0080);
        end

        tick();
        mem_lat = 1;
        redirect_pulse(BRANCH_ABSOLUTE, 32'h0, 32'h0, 32'hFFFF_FFFF);
        wait_req_hs(a, saw);
        check("t6_top_addr", a, 32'hFFFF_FFFC);
        tick();
        mem_lat = 3;
        wait_req_hs(a, saw);
        check("t6_wrap_addr", a, 32'h0000_0000);
        tick();
        do_reset();

        ready_mode = 2;
        mem_lat = 0;
        accepted = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            inst_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            branch_type = branch_type_e'(2'($urandom_range(0, 2)));
            branch_pc = $urandom() & 32'hFFFF_FFFC;
            branch_imm = 32'($signed(12'($urandom_range(0, 4095))));
            alu_result = $urandom();
        end
        tick();
        redirect_valid = 1'b0;
        branch_type = BRANCH_NONE;
        check("rand_progress", 32'(accepted > 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
